// File: rtl/sprite_line_pkg.sv
// Shared types and helpers for the sprite line engine.
//   state_t      : engine FSM states
//   OFS_*        : byte offsets of the four attribute bytes of a sprite
//   attr_t       : decoded sprite attributes {x, y, tile, color, flip}
//   transparent(): true when every used bitplane of a pixel is 1
// Optional feature macro: SPRITE_XFLIP_EN (decoded in sprite_line_engine).
package sprite_line_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CHECK,
    ST_FETCH0,
    ST_FETCH1,
    ST_EMIT,
    ST_NEXT
  } state_t;

  localparam logic [1:0] OFS_X    = 2'd0;
  localparam logic [1:0] OFS_TILE = 2'd1;
  localparam logic [1:0] OFS_Y    = 2'd2;
  localparam logic [1:0] OFS_HI   = 2'd3;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [9:0] tile;
    logic [3:0] color;
    logic       flip;
  } attr_t;

  localparam int MAX_PLANES = 8;

  // Only the low 'planes' bits take part; the rest of the vector is ignored.
  function automatic logic transparent(input logic [MAX_PLANES-1:0] pix, input int planes);
    logic t;
    t = 1'b1;
    for (int p = 0; p < MAX_PLANES; p++) begin
      if (p < planes) t = t & pix[p];
    end
    return t;
  endfunction

endpackage

// File: rtl/sprite_attr_ram.sv
// Sprite attribute byte RAM.
//   clk, RESETn          : clock, synchronous active-low reset (cpu_dout only)
//   cpu_cs/cpu_we        : CPU select / write strobe
//   cpu_addr, cpu_din    : CPU byte address and write data
//   cpu_dout             : registered CPU read data, updates on cpu_cs&!cpu_we
//   eng_addr, eng_dout   : engine read port, one cycle latency
// A read of a byte written in the same cycle returns the previous contents.
module sprite_attr_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          RESETn,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  input  logic [AW-1:0] eng_addr,
  output logic [7:0]    eng_dout
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cpu_cs && cpu_we) mem[cpu_addr] <= cpu_din;
    eng_dout <= mem[eng_addr];
  end

  always_ff @(posedge clk) begin
    if (!RESETn)                cpu_dout <= '0;
    else if (cpu_cs && !cpu_we) cpu_dout <= mem[cpu_addr];
  end

endmodule

// File: rtl/sprite_line_engine.sv
// Sprite line engine: on each line_start scans every sprite against line_v,
// fetches the matching tile row (two 8-pixel halves) from graphics ROM and
// streams the opaque pixels to a line-buffer writer.
//   clk, RESETn              : clock, synchronous active-low reset
//   cpu_cs/we/addr/din/dout  : CPU access to the attribute RAM
//   line_start, line_v       : start pulse and line number to prepare
//   rom_req/addr/ack/data    : graphics ROM fetch, addr = {tile, row, half}
//   out_valid/ready/x/pix/color : pixel beat stream
//   busy, overflow           : line in progress / too many sprites on line
//   dbg_state                : current FSM state
// Optional feature macro: SPRITE_XFLIP_EN -- byte3[5] becomes the X flip
// bit, the top tile bit is forced to 0 and byte3[6] supplies tile[8].
module sprite_line_engine
  import sprite_line_pkg::*;
#(
  parameter int NUM_SPRITES  = 64,
  parameter int PLANES       = 3,
  parameter int TILE_BITS    = 10,
  parameter int ROW_BITS     = 4,
  parameter int MAX_PER_LINE = 16
) (
  input  logic                            clk,
  input  logic                            RESETn,
  input  logic                            cpu_cs,
  input  logic                            cpu_we,
  input  logic [$clog2(NUM_SPRITES)+1:0]  cpu_addr,
  input  logic [7:0]                      cpu_din,
  output logic [7:0]                      cpu_dout,
  input  logic                            line_start,
  input  logic [8:0]                      line_v,
  output logic                            rom_req,
  output logic [TILE_BITS+ROW_BITS:0]     rom_addr,
  input  logic                            rom_ack,
  input  logic [8*PLANES-1:0]             rom_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [8:0]                      out_x,
  output logic [PLANES-1:0]               out_pix,
  output logic [3:0]                      out_color,
  output logic                            busy,
  output logic                            overflow,
  output state_t                          dbg_state
);

  localparam int IW = $clog2(NUM_SPRITES);
  localparam int HW = $clog2(MAX_PER_LINE + 1);

  state_t                state, state_nx;
  logic [IW-1:0]         idx;
  logic [2:0]            rd_cnt;
  logic [7:0]            attr_b [4];
  logic [7:0]            eng_dout;
  logic [8:0]            line_q;
  logic [ROW_BITS-1:0]   row_q;
  logic [HW-1:0]         hit_cnt;
  logic [8*PLANES-1:0]   rom_h0, rom_h1;
  logic [3:0]            k;
  logic                  k_done;

  attr_t                 attr;
  logic [8:0]            row9;
  logic                  hit;
  logic [3:0]            src;
  logic [8*PLANES-1:0]   hdata;
  logic [2:0]            bsel;
  logic [PLANES-1:0]     cur_pix;
  logic [MAX_PLANES-1:0] pix_ext;
  logic                  cur_opaque;
  logic                  beat_free;
  logic                  step;
  logic                  unused_bits;

  sprite_attr_ram #(.DEPTH(4*NUM_SPRITES), .AW(IW+2)) u_ram (
    .clk      (clk),
    .RESETn   (RESETn),
    .cpu_cs   (cpu_cs),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_din  (cpu_din),
    .cpu_dout (cpu_dout),
    .eng_addr ({idx, rd_cnt[1:0]}),
    .eng_dout (eng_dout)
  );

  always_comb begin
    attr       = '0;
    attr.x     = {attr_b[OFS_HI][4], attr_b[OFS_X]};
    attr.y     = {attr_b[OFS_HI][7], attr_b[OFS_Y]};
    attr.color = attr_b[OFS_HI][3:0];
`ifdef SPRITE_XFLIP_EN
    attr.tile  = {1'b0, attr_b[OFS_HI][6], attr_b[OFS_TILE]};
    attr.flip  = attr_b[OFS_HI][5];
`else
    attr.tile  = {attr_b[OFS_HI][6:5], attr_b[OFS_TILE]};
    attr.flip  = 1'b0;
`endif
  end

  assign unused_bits = ^{attr};

  // Row within the sprite; wraps mod 512 so sprites straddle line 0.
  always_comb begin
    row9 = line_q - attr.y;
    hit  = (row9 < 9'(2**ROW_BITS));
  end

  // Pixel at position k; a flipped sprite reads source pixel 15-k.
  always_comb begin
`ifdef SPRITE_XFLIP_EN
    src = attr.flip ? ~k : k;
`else
    src = k;
`endif
    hdata   = src[3] ? rom_h1 : rom_h0;
    bsel    = 3'd7 - src[2:0];
    cur_pix = '0;
    for (int p = 0; p < PLANES; p++) cur_pix[p] = hdata[8*p + int'(bsel)];
    pix_ext = '0;
    pix_ext[PLANES-1:0] = cur_pix;
    cur_opaque = !transparent(pix_ext, PLANES);
  end

  // Beat handshake: a beat is offered while out_valid=1 and its x/pix/color
  // hold until the cycle with out_valid&out_ready, when it completes. Only
  // then (or with no beat offered) is the next pixel position processed.
  assign beat_free = !out_valid || out_ready;
  assign step      = (state == ST_EMIT) && !k_done && beat_free;

  always_ff @(posedge clk) begin
    if (!RESETn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (line_start) begin
      state_nx = ST_READ;
    end else begin
      case (state)
        ST_IDLE:   state_nx = ST_IDLE;
        ST_READ:   if (rd_cnt == 3'd4) state_nx = ST_CHECK;
        ST_CHECK:  begin
          if (!hit)                               state_nx = ST_NEXT;
          else if (hit_cnt == HW'(MAX_PER_LINE))  state_nx = ST_IDLE;
          else                                    state_nx = ST_FETCH0;
        end
        ST_FETCH0: if (rom_ack) state_nx = ST_FETCH1;
        ST_FETCH1: if (rom_ack) state_nx = ST_EMIT;
        ST_EMIT:   if (k_done && beat_free) state_nx = ST_NEXT;
        ST_NEXT:   state_nx = (idx == IW'(NUM_SPRITES-1)) ? ST_IDLE : ST_READ;
        default:   state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rom_req   = (state == ST_FETCH0) || (state == ST_FETCH1);
    rom_addr  = rom_req ? {attr.tile[TILE_BITS-1:0], row_q, state == ST_FETCH1} : '0;
    busy      = (state != ST_IDLE);
    dbg_state = state;
  end

  always_ff @(posedge clk) begin
    if (!RESETn) begin
      idx       <= '0;
      rd_cnt    <= '0;
      for (int i = 0; i < 4; i++) attr_b[i] <= '0;
      line_q    <= '0;
      row_q     <= '0;
      hit_cnt   <= '0;
      overflow  <= 1'b0;
      rom_h0    <= '0;
      rom_h1    <= '0;
      k         <= '0;
      k_done    <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_pix   <= '0;
      out_color <= '0;
    end else if (line_start) begin
      idx       <= '0;
      rd_cnt    <= '0;
      hit_cnt   <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      line_q    <= line_v;
    end else begin
      case (state)
        ST_READ: begin
          rd_cnt <= rd_cnt + 3'd1;
          // Data for the byte addressed last cycle arrives now.
          if (rd_cnt != 3'd0) attr_b[rd_cnt[1:0] - 2'd1] <= eng_dout;
        end
        ST_CHECK: begin
          row_q  <= row9[ROW_BITS-1:0];
          k      <= '0;
          k_done <= 1'b0;
          if (hit && hit_cnt == HW'(MAX_PER_LINE)) overflow <= 1'b1;
          else if (hit)                            hit_cnt  <= hit_cnt + HW'(1);
        end
        ST_FETCH0: if (rom_ack) rom_h0 <= rom_data;
        ST_FETCH1: if (rom_ack) rom_h1 <= rom_data;
        ST_EMIT: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (step) begin
            if (cur_opaque) begin
              out_valid <= 1'b1;
              out_x     <= attr.x + 9'(k);
              out_pix   <= cur_pix;
              out_color <= attr.color;
            end
            if (k == 4'd15) k_done <= 1'b1;
            else            k      <= k + 4'd1;
          end
        end
        ST_NEXT: begin
          rd_cnt <= '0;
          idx    <= (idx == IW'(NUM_SPRITES-1)) ? '0 : idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_line_engine.sv
// Directed bench for sprite_line_engine with a ROM responder, a pixel sink
// and expected-value queues filled from a line model of the attribute image.
module tb_sprite_line_engine;
  import sprite_line_pkg::*;

  localparam int NS  = 64;
  localparam int PL  = 3;
  localparam int MPL = 16;
  localparam int RAW = 15;
  localparam int DW  = 8*PL;
  localparam int BW  = 9 + PL + 4;

  logic           clk = 1'b0;
  logic           RESETn = 1'b0;
  logic           cpu_cs = 1'b0;
  logic           cpu_we = 1'b0;
  logic [7:0]     cpu_addr = '0;
  logic [7:0]     cpu_din = '0;
  logic [7:0]     cpu_dout;
  logic           line_start = 1'b0;
  logic [8:0]     line_v = '0;
  logic           rom_req;
  logic [RAW-1:0] rom_addr;
  logic           rom_ack;
  logic [DW-1:0]  rom_data;
  logic           out_valid;
  logic           out_ready;
  logic [8:0]     out_x;
  logic [PL-1:0]  out_pix;
  logic [3:0]     out_color;
  logic           busy;
  logic           overflow;
  state_t         dbg_state;

  int total = 0;
  int bad   = 0;
  int ack_dly = 0;
  int rdy_lag = 0;
  int rom_mode = 0;

  logic [BW-1:0]  exp_q[$];
  logic [RAW-1:0] exp_addr_q[$];
  logic [7:0]     ram_img [256];

  sprite_line_engine dut (
    .clk        (clk),
    .RESETn     (RESETn),
    .cpu_cs     (cpu_cs),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .line_start (line_start),
    .line_v     (line_v),
    .rom_req    (rom_req),
    .rom_addr   (rom_addr),
    .rom_ack    (rom_ack),
    .rom_data   (rom_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_pix    (out_pix),
    .out_color  (out_color),
    .busy       (busy),
    .overflow   (overflow),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Graphics ROM contents: hashed pattern (mode 0) or all zero (mode 1).
  function automatic logic [DW-1:0] rom_fn(input logic [RAW-1:0] a);
    logic [15:0] h;
    if (rom_mode == 1) return '0;
    h = 16'(a) * 16'h9E37;
    h = h ^ (h >> 7);
    return {h[7:0] | 8'hC3, h[15:8] | 8'h3C, h[11:4] | 8'h99};
  endfunction

  // Line model: which sprites hit, which ROM rows are fetched, which beats result.
  task automatic build_line(input logic [8:0] lv, output bit ovf);
    int hits;
    hits = 0;
    ovf  = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < NS; i++) begin
      logic [7:0]     b0, b1, b2, b3;
      logic [8:0]     x, y, row;
      logic [9:0]     tile;
      logic [3:0]     col;
      logic           fl;
      logic [DW-1:0]  d [2];
      logic [RAW-1:0] a;
      logic [DW-1:0]  dd;
      logic [PL-1:0]  pix;
      int             s, bitn;
      b0 = ram_img[4*i];   b1 = ram_img[4*i+1];
      b2 = ram_img[4*i+2]; b3 = ram_img[4*i+3];
      x   = {b3[4], b0};
      y   = {b3[7], b2};
      col = b3[3:0];
`ifdef SPRITE_XFLIP_EN
      tile = {1'b0, b3[6], b1};
      fl   = b3[5];
`else
      tile = {b3[6:5], b1};
      fl   = 1'b0;
`endif
      row = lv - y;
      if (row < 9'd16) begin
        if (hits == MPL) begin
          ovf = 1'b1;
          break;
        end
        hits++;
        for (int h = 0; h < 2; h++) begin
          a = {tile, row[3:0], h[0]};
          exp_addr_q.push_back(a);
          d[h] = rom_fn(a);
        end
        for (int kk = 0; kk < 16; kk++) begin
          s    = fl ? 15 - kk : kk;
          dd   = (s >= 8) ? d[1] : d[0];
          bitn = 7 - (s % 8);
          for (int p = 0; p < PL; p++) pix[p] = dd[8*p + bitn];
          if (pix != {PL{1'b1}}) exp_q.push_back({x + 9'(kk), pix, col});
        end
      end
    end
  endtask

  // ---------------- ROM responder ----------------
  initial begin : rom_proc
    int wait_cnt;
    logic [RAW-1:0] held;
    wait_cnt = 0;
    held = '0;
    rom_ack = 1'b0;
    rom_data = '0;
    forever begin
      @(negedge clk);
      rom_ack  = 1'b0;
      rom_data = DW'($urandom);
      if (line_start || !RESETn) begin
        wait_cnt = 0;
      end else if (rom_req) begin
        if (wait_cnt == 0) held = rom_addr;
        else chk("rom_addr_stable", 32'(rom_addr), 32'(held));
        if (wait_cnt >= ack_dly) begin
          chk("rom_addr", 32'(rom_addr),
              (exp_addr_q.size() != 0) ? 32'(exp_addr_q.pop_front()) : 32'hDEADBEEF);
          rom_ack  = 1'b1;
          rom_data = rom_fn(rom_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        rom_ack  = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- pixel sink / scoreboard ----------------
  initial begin : sink_proc
    int w;
    logic [BW-1:0] held_b, cur;
    w = 0;
    held_b = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cur = {out_x, out_pix, out_color};
      if (line_start || !RESETn) begin
        out_ready = 1'b0;
        w = 0;
      end else if (out_valid) begin
        if (w == 0) held_b = cur;
        else chk("beat_stable", 32'(cur), 32'(held_b));
        if (w >= rdy_lag) begin
          out_ready = 1'b1;
          w = 0;
          chk("beat", 32'(cur), (exp_q.size() != 0) ? 32'(exp_q.pop_front()) : 32'hDEADBEEF);
        end else begin
          out_ready = 1'b0;
          w++;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        w = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
    @(posedge clk); #2;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_din = d;
    ram_img[a] = d;
    @(posedge clk); #2;
    cpu_cs = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic set_sprite(input int i, input logic [8:0] x, input logic [8:0] y,
                            input logic [9:0] tile, input logic [3:0] col);
    cpu_write(8'(4*i),     x[7:0]);
    cpu_write(8'(4*i + 1), tile[7:0]);
    cpu_write(8'(4*i + 2), y[7:0]);
    cpu_write(8'(4*i + 3), {y[8], tile[9:8], x[8], col});
  endtask

  task automatic cpu_read_chk(input logic [7:0] a);
    @(posedge clk); #2;
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    @(posedge clk); #2;
    cpu_cs = 1'b0; cpu_addr = a ^ 8'h01;
    chk("cpu_dout", 32'(cpu_dout), 32'(ram_img[a]));
    @(posedge clk); #2;
    chk("cpu_dout_hold", 32'(cpu_dout), 32'(ram_img[a]));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_in_time"}, 32'(n < 20000), 32'd1);
  endtask

  task automatic run_line(input string tag, input logic [8:0] lv);
    bit ovf;
    build_line(lv, ovf);
    @(posedge clk); #2;
    line_v = lv; line_start = 1'b1;
    @(posedge clk); #2;
    line_start = 1'b0;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    chk({tag, "_ovf_start"}, 32'(overflow), 32'd0);
    wait_idle(tag);
    @(negedge clk);
    chk({tag, "_overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_fetch_left"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main_proc
    bit ovf;
    int n;

    // reset
    RESETn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cpu_dout",  32'(cpu_dout),  32'd0);
    chk("rst_rom_req",   32'(rom_req),   32'd0);
    chk("rst_rom_addr",  32'(rom_addr),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_x",     32'(out_x),     32'd0);
    chk("rst_out_pix",   32'(out_pix),   32'd0);
    chk("rst_out_color", 32'(out_color), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_overflow",  32'(overflow),  32'd0);
    chk("rst_state",     32'(dbg_state), 32'(ST_IDLE));
    RESETn = 1'b1;

    // park every sprite far below the tested lines
    for (int i = 0; i < NS; i++) set_sprite(i, 9'h000, 9'h180, 10'h000, 4'h0);
    set_sprite(0, 9'h010, 9'h020, 10'd5, 4'd3);
    cpu_read_chk(8'h00);
    cpu_read_chk(8'h01);
    cpu_read_chk(8'h02);
    cpu_read_chk(8'h03);
    cpu_read_chk(8'h16);

    // basic hit, then a line where the sprite is just out of range
    run_line("hit", 9'h023);
    run_line("row16", 9'h030);

    // X wrap with all-opaque data
    set_sprite(1, 9'h1F8, 9'h040, 10'h2AB, 4'hA);
    rom_mode = 1;
    run_line("xwrap", 9'h045);
    rom_mode = 0;

    // 17 sprites on one line
    for (int i = 2; i < 19; i++)
      set_sprite(i, 9'(i * 20), 9'h060, 10'(i * 7), 4'(i));
    run_line("ovf", 9'h061);

    // slow ROM and slow sink
    ack_dly = 5;
    rdy_lag = 3;
    run_line("slow_hit", 9'h023);
    run_line("slow_ovf", 9'h06F);
    run_line("slow_wrap", 9'h04F);

    // abort while emitting pixels
    ack_dly = 0;
    rdy_lag = 2;
    build_line(9'h023, ovf);
    @(posedge clk); #2;
    line_v = 9'h023; line_start = 1'b1;
    @(posedge clk); #2;
    line_start = 1'b0;
    n = 0;
    while (!out_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reach_emit", 32'(n < 3000), 32'd1);
    @(posedge clk); #2;
    line_start = 1'b1;
    build_line(9'h023, ovf);
    @(posedge clk); #1;
    chk("abort_valid_drop", 32'(out_valid), 32'd0);
    chk("abort_req_low",    32'(rom_req),   32'd0);
    chk("abort_busy",       32'(busy),      32'd1);
    chk("abort_state",      32'(dbg_state), 32'(ST_READ));
    #1;
    line_start = 1'b0;
    wait_idle("abort");
    chk("abort_beats_left", 32'(exp_q.size()), 32'd0);
    chk("abort_fetch_left", 32'(exp_addr_q.size()), 32'd0);

    // byte3[5] set on sprite 0: flip bit, or tile[8] without the flip feature
    rdy_lag = 0;
    cpu_write(8'h03, 8'h23);
    run_line("flip", 9'h023);

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
